// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer write path.
package fb_pkg;

  localparam int unsigned FB_DATA_W = 24;
  localparam int unsigned FB_ADDR_W = 18;
  localparam int unsigned FB_IMG_W  = 320;
  localparam int unsigned FB_IMG_H  = 240;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, DONE} fbw_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Counter width that stays legal for single-entry dimensions.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_addr_counter.sv
// Row-major x/y/address counter; the address is a running sum, so no multiplier.
module fb_addr_counter
  import fb_pkg::*;
#(
  parameter int unsigned IMG_W     = FB_IMG_W,
  parameter int unsigned IMG_H     = FB_IMG_H,
  parameter int unsigned ADDR_W    = FB_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic              resync_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              origin_o,
  output logic              frame_last_o
);

  localparam int unsigned XW = cnt_width(IMG_W);
  localparam int unsigned YW = cnt_width(IMG_H);
  localparam logic [ADDR_W-1:0] Base  = ADDR_W'(BASE_ADDR);
  localparam logic [XW-1:0]     XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YLast = YW'(IMG_H - 1);

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = Base;
    end else if (resync_i) begin
      // Resync beat itself lands on the origin; the next one goes to (1,0).
      x_d    = XW'(1);
      y_d    = '0;
      addr_d = Base + ADDR_W'(1);
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_W'(1);
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= Base;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o       = addr_q;
  assign origin_o     = (x_q == '0) && (y_q == '0);
  assign frame_last_o = (x_q == XLast) && (y_q == YLast);

endmodule

// File: rtl/frame_buffer_writer.sv
// Port-A writer for the frame memory: one registered write per accepted pixel beat.
// Optional full-frame clear is enabled with FRAME_BUFFER_WRITER_CLEAR_EN.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int unsigned IMG_W     = FB_IMG_W,
  parameter int unsigned IMG_H     = FB_IMG_H,
  parameter int unsigned ADDR_W    = FB_ADDR_W,
  parameter int unsigned DATA_W    = FB_DATA_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef FRAME_BUFFER_WRITER_CLEAR_EN
  input  logic              clear_req_i,
  input  logic [DATA_W-1:0] clear_color_i,
`endif
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_sof_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              sof_err_o
);

  localparam longint unsigned Span = 64'(BASE_ADDR) + 64'(IMG_W) * 64'(IMG_H);
  if (Span > (64'd1 << ADDR_W)) begin : g_range_err
    $error("frame_buffer_writer: frame does not fit in ADDR_W address space");
  end

  fbw_state_t        state_q, state_d;
  logic              clear_go, start_go, accept, resync, cnt_clear, cnt_inc;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_origin, cnt_last;
  logic              we_q, we_d, sof_err_q, sof_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, fill_color;

`ifdef FRAME_BUFFER_WRITER_CLEAR_EN
  logic [DATA_W-1:0] color_q;

  assign clear_go   = (state_q == IDLE) && clear_req_i;
  assign fill_color = color_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         color_q <= '0;
    else if (clear_go) color_q <= clear_color_i;
  end
`else
  assign clear_go   = 1'b0;
  assign fill_color = '0;
`endif

  assign start_go  = (state_q == IDLE) && start_i && !clear_go;
  assign accept    = (state_q == WRITE) && in_valid_i;
  assign resync    = accept && in_sof_i && !cnt_origin;
  assign cnt_clear = start_go || clear_go;
  assign cnt_inc   = (accept && !resync) || (state_q == CLEAR);

  fb_addr_counter #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_cnt (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (cnt_clear),
    .inc_i        (cnt_inc),
    .resync_i     (resync),
    .addr_o       (cnt_addr),
    .origin_o     (cnt_origin),
    .frame_last_o (cnt_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (clear_go)      state_d = CLEAR;
        else if (start_go) state_d = WRITE;
      end
      WRITE:   if (accept && !resync && cnt_last) state_d = DONE;
      CLEAR:   if (cnt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d      = accept || (state_q == CLEAR);
    addr_d    = resync ? ADDR_W'(BASE_ADDR) : cnt_addr;
    wdata_d   = (state_q == CLEAR) ? fill_color : in_data_i;
    sof_err_d = sof_err_q;
    if (start_go)    sof_err_d = 1'b0;
    else if (resync) sof_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sof_err_q <= 1'b0;
    end else begin
      we_q      <= we_d;
      sof_err_q <= sof_err_d;
      if (we_d) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
      end
    end
  end

  always_comb begin
    in_ready_o   = (state_q == WRITE);
    busy_o       = (state_q != IDLE);
    frame_done_o = (state_q == DONE);
    mem_we_o     = we_q;
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
    sof_err_o    = sof_err_q;
  end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Write-side companion of the frame-buffer read path. The HDMI scan-out reads port B of the dual-port frame memory; this block fills the same memory through port A.
- Accepts a valid/ready pixel stream of 24-bit RGB words from the processor or loader side.
- Generates row-major addresses from BASE_ADDR and issues one registered write per accepted pixel.
- Signals end of frame with a single-cycle pulse.

Parameters:
- IMG_W, 320, pixels per row.
- IMG_H, 240, rows per frame.
- ADDR_W, 18, frame-memory address width.
- DATA_W, 24, pixel/colour width.
- BASE_ADDR, 0, address of pixel (0,0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame.
- in_valid  input  1  pixel beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  DATA_W  pixel colour.
- in_sof  input  1  marks the first pixel of a frame; qualified by in_valid.
- mem_we  output  1  port-A write enable.
- mem_addr  output  ADDR_W  port-A address.
- mem_wdata  output  DATA_W  port-A write data.
- busy  output  1  high whenever state is not IDLE.
- frame_done  output  1  one-cycle pulse after the last write.
- sof_err  output  1  sticky flag: in_sof seen mid-frame.

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset: all outputs 0, state IDLE, x/y counters 0, address counter = BASE_ADDR.
- States:
  - IDLE: in_ready=0. start=1 -> WRITE; counters cleared; sof_err cleared.
  - WRITE: in_ready=1. A beat is accepted when in_valid & in_ready.
  - DONE: in_ready=0, lasts one cycle, then IDLE.
- Accepted beat:
  - Next cycle: mem_we=1, mem_addr = address of that beat, mem_wdata = in_data. Latency is 1 cycle.
  - mem_we is 0 in every cycle that does not follow an accepted beat.
- Counters:
  - x increments per beat.
  - At x=IMG_W-1: x wraps to 0 and y increments.
  - The address is a running counter incremented by 1 per beat. No multiplier is used; the address always equals BASE_ADDR + y*IMG_W + x.
- Last pixel: a beat accepted at x=IMG_W-1, y=IMG_H-1 moves WRITE -> DONE.
  - In the DONE cycle: mem_we=1 for that pixel and frame_done=1, in the same cycle.
- in_sof on an accepted beat at pixel (0,0): normal behaviour.
- in_sof on an accepted beat at any other position (resync):
  - sof_err set (sticky).
  - The beat is written to BASE_ADDR.
  - Counters restart so that the next beat goes to pixel (0,1-col), i.e. x=1, y=0.
- start while in WRITE or DONE: ignored.
- in_valid in IDLE or DONE: ignored, no write.
- Back-pressure is never applied mid-frame; in_ready stays high for the whole of WRITE.
- rst mid-frame: immediate return to IDLE with mem_we=0. Pixels already written stay in memory; no frame_done.
- Width rules: address arithmetic is ADDR_W-bit unsigned. Requires BASE_ADDR + IMG_W*IMG_H <= 2**ADDR_W, checked by an elaboration-time assertion.

Optional Feature:
- Macro: FRAME_BUFFER_WRITER_CLEAR_EN.
- With the macro defined:
  - Adds ports clear_req (input, 1) and clear_color (input, DATA_W).
  - Adds state CLEAR, entered from IDLE on clear_req. clear_req wins if asserted together with start.
  - CLEAR writes clear_color to all IMG_W*IMG_H addresses, one per cycle: mem_we=1 continuously, in_ready=0.
  - CLEAR then passes through DONE, so frame_done pulses.
  - clear_color is sampled once, on entry.
- Without the macro: no extra ports, no CLEAR state, and identical behaviour otherwise.

Decomposition:
- Package fb_pkg: DATA_W/ADDR_W defaults, IMG_W/IMG_H defaults, state enum fbw_state_t {IDLE, WRITE, CLEAR, DONE}, rgb_t typedef (24-bit packed r/g/b).
- One sub-module, fb_addr_counter: x/y/address counter with clear, increment and wrap outputs. It is shared with CLEAR.

Test Plan (IMG_W=4, IMG_H=2, BASE_ADDR=16):
- Basic frame: start, then 8 back-to-back beats with data 0x000001..0x000008 and in_sof on beat 1 -> writes to addr 16..23 with matching data, each 1 cycle after acceptance; frame_done pulses once, in the same cycle as the addr-23 write; busy falls the cycle after.
- Gapped stream: in_valid toggles 1,0,1,0 -> exactly 8 writes at addresses 16..23 and no write on idle cycles.
- Mid-frame resync: in_sof asserted on beat 4 -> sof_err=1 and beat 4 is written to 16; the following 7 beats go to 17..23, then frame_done; sof_err stays 1 until the next start.
- Reset and ignored inputs:
  - rst after beat 5 -> mem_we=0 immediately, no frame_done, busy=0; a new start then writes from 16.
  - start pulses during WRITE and in_valid in IDLE -> no effect.
- With FRAME_BUFFER_WRITER_CLEAR_EN: clear_req with clear_color=0x00FF00 -> 8 consecutive writes of 0x00FF00 to 16..23, in_ready=0 throughout, frame_done at the end; start asserted in the same cycle as clear_req is ignored.
